data_mem_param: RTL and testbench
=================================

Name: data_mem_param

Overview:
- Parametrised single-port data memory for the CSE141L core; successor to the fixed 8x256 data RAM.
- Width and depth are generic.
- Clearing is done sequentially by an init state machine, one word per cycle, instead of a single-cycle array reset. Software can also request a clear at run time.
- Reads are registered, with a valid strobe. The block sits between the core's load/store stage and its data address path.

Parameters:
- DW, 8, data word width in bits
- AW, 8, address width in bits
- DEPTH, 256, number of words; must be <= 2**AW
- INIT_VAL, 0, value written to every word during a clear (DW bits)

Ports:
- Clk  input  1  system clock; all state updates on posedge Clk
- Reset  input  1  synchronous, active-high reset
- WriteEn  input  1  write request for the current cycle
- ReadEn  input  1  read request for the current cycle
- ClrReq  input  1  single-cycle pulse requesting a full memory clear
- DataAddress  input  AW  shared read/write word address
- DataIn  input  DW  write data
- DataOut  output  DW  registered read data
- ReadValid  output  1  DataOut carries the result of the read issued in the previous cycle
- Busy  output  1  clear in progress; read and write requests are ignored

Behaviour:
- FSM states: S_CLEAR, S_IDLE.
- Reset (sampled high at a clock edge):
  - state <= S_CLEAR; clear pointer <= 0.
  - DataOut <= 0, ReadValid <= 0, Busy <= 1.
  - No array write occurs while Reset is high.
- S_CLEAR:
  - Each cycle: Core[ptr] <= INIT_VAL, then ptr++.
  - The cycle that writes ptr == DEPTH-1 sets next state S_IDLE and ptr <= 0.
  - So after Reset falls, Busy stays high for exactly DEPTH cycles.
- Busy is a registered output and equals (state == S_CLEAR).
- While Busy: WriteEn and ReadEn are ignored, ReadValid is 0 and DataOut holds its value. ClrReq is ignored; the clear does not restart.
- S_IDLE, write: WriteEn high and DataAddress < DEPTH gives Core[DataAddress] <= DataIn at the edge.
- S_IDLE, read:
  - ReadEn high at edge n gives DataOut = Core[DataAddress] and ReadValid = 1 after edge n.
  - ReadValid is a one-cycle pulse per accepted read. Back-to-back reads give a ReadValid high every cycle.
  - DataOut holds its last value when no read completes.
- Read and write in the same cycle to the same address: read returns the old contents (read-before-write); the write still commits.
- Out-of-range address (DataAddress >= DEPTH): write dropped; read returns 0 with ReadValid = 1.
- ClrReq in S_IDLE:
  - Next state S_CLEAR, ptr <= 0.
  - Any WriteEn or ReadEn in the same cycle is dropped; ClrReq has priority.
  - Busy rises on the next cycle.
- Reset asserted mid-clear restarts the clear from ptr 0 after Reset falls.
- Clear-pointer width: AW+1 bits, so DEPTH = 2**AW terminates without wrap ambiguity.

Optional Feature:
- Macro: DATA_MEM_PARITY_EN.
- Defined:
  - Each word is stored as DW+1 bits, with even parity over the data.
  - Extra input ParInject (1 bit): when high during an accepted write, the stored parity bit is inverted.
  - Extra output ParErr (1 bit): registered, valid with ReadValid; 1 when the read word's parity mismatches; reset 0.
  - Clear writes INIT_VAL with correct parity.
- Undefined: no parity storage, no ParInject/ParErr ports; behaviour otherwise identical.

Decomposition:
- Package data_mem_pkg: state enum typedef (S_CLEAR, S_IDLE), default width/depth constants, parity helper function.
- Sub-module data_mem_init_fsm: state register, clear pointer, Busy generation; exports clear-write enable and clear address to the top.
- Array, read register and port muxing stay in data_mem_param.

Test Plan:
- Reset 2 cycles, then release: Busy high exactly 256 cycles; ReadEn at address 0x10 after Busy falls gives DataOut = 0x00, ReadValid = 1 one cycle later.
- Write 0xA5 to 0x3C, next cycle read 0x3C: DataOut = 0xA5 with ReadValid one cycle after the read; ReadValid low on idle cycles.
- Same cycle: WriteEn with 0x77 and ReadEn at 0x3C (holds 0xA5): DataOut = 0xA5; a following read returns 0x77.
- ClrReq pulse together with WriteEn of 0x11 to 0x05:
  - write dropped;
  - Busy high 256 cycles;
  - WriteEn during Busy ignored;
  - afterwards all addresses read INIT_VAL.
- DEPTH = 200, AW = 8: write 0xFF to 0xC8, then read 0xC8: DataOut = 0x00, ReadValid = 1; address 0xC7 unaffected.
- DATA_MEM_PARITY_EN defined:
  - write 0x5A with ParInject = 1, then read: ParErr = 1 with ReadValid;
  - rewrite without injection, then read: ParErr = 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types for data_mem_param: FSM states, default sizes, parity helper.
// Optional parity storage is enabled with DATA_MEM_PARITY_EN.
package data_mem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 256;
  localparam int PAR_W     = 64;

  // Even parity bit: makes the total count of ones even.
  function automatic logic even_par(
    input logic [PAR_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/data_mem_init_fsm.sv
// Clear sequencer: walks a pointer over every word after reset or ClrReq.
// Ports: clk, reset, clr_req in; busy, clr_we, clr_addr out.
module data_mem_init_fsm #(
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [IW-1:0] clr_addr
);
  import data_mem_pkg::*;

  // One extra bit so DEPTH == 2**AW ends cleanly.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  state_t      state, state_nxt;
  logic [AW:0] ptr, ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      busy  <= (state_nxt == S_CLEAR);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      S_CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
        end
      end
    endcase
  end

  assign clr_we   = (state == S_CLEAR) && !reset;
  assign clr_addr = ptr[IW-1:0];

endmodule

// File: rtl/data_mem_param.sv
// Parametrised single-port data memory, sequential clear, registered read.
// Ports: Clk, Reset, WriteEn, ReadEn, ClrReq, DataAddress, DataIn in;
// DataOut, ReadValid, Busy out. DATA_MEM_PARITY_EN adds ParInject/ParErr.
module data_mem_param #(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter int            DEPTH    = 256,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEn,
  input  logic          ReadEn,
  input  logic          ClrReq,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
`ifdef DATA_MEM_PARITY_EN
  input  logic          ParInject,
  output logic          ParErr,
`endif
  output logic [DW-1:0] DataOut,
  output logic          ReadValid,
  output logic          Busy
);
  import data_mem_pkg::*;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATA_MEM_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [SW-1:0] core [DEPTH];

  logic          clr_we;
  logic [IW-1:0] clr_addr;
  logic          in_range;
  logic          acc;
  logic          wr_ok;
  logic          rd_ok;
  logic [IW-1:0] idx;
  logic [SW-1:0] wr_word;
  logic [SW-1:0] clr_word;
  logic [SW-1:0] rd_word;

  data_mem_init_fsm #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_fsm (
    .clk      (Clk),
    .reset    (Reset),
    .clr_req  (ClrReq),
    .busy     (Busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign in_range = {1'b0, DataAddress} < DEPTH_L;
  assign idx      = DataAddress[IW-1:0];
  // ClrReq wins over any same-cycle access.
  assign acc      = !Reset && !Busy && !ClrReq;
  assign wr_ok    = acc && WriteEn && in_range;
  assign rd_ok    = acc && ReadEn;

`ifdef DATA_MEM_PARITY_EN
  assign wr_word  = {even_par(PAR_W'(DataIn)) ^ ParInject, DataIn};
  assign clr_word = {even_par(PAR_W'(INIT_VAL)), INIT_VAL};
`else
  assign wr_word  = DataIn;
  assign clr_word = INIT_VAL;
`endif

  // Out-of-range reads return zero (with good parity).
  assign rd_word = in_range ? core[idx] : '0;

  always_ff @(posedge Clk) begin
    if (clr_we) begin
      core[clr_addr] <= clr_word;
    end else if (wr_ok) begin
      core[idx] <= wr_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      DataOut   <= '0;
      ReadValid <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
      ParErr    <= 1'b0;
`endif
    end else begin
      ReadValid <= rd_ok;
      if (rd_ok) begin
        DataOut <= rd_word[DW-1:0];
`ifdef DATA_MEM_PARITY_EN
        ParErr  <= even_par(PAR_W'(rd_word[DW-1:0])) ^ rd_word[DW];
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: directed plan plus random traffic, two depths.
// Checks both instances against a word-level model every cycle.
module tb_data_mem_param;

  localparam int DA = 256;
  localparam int DB = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic       clr = 1'b0;
  logic       inj = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] din  = '0;

  logic [7:0] a_do, b_do;
  logic       a_rv, b_rv, a_bz, b_bz;
`ifdef DATA_MEM_PARITY_EN
  logic       a_pe, b_pe;
`endif

  data_mem_param #(.DW(8), .AW(8), .DEPTH(DA), .INIT_VAL(8'h00)) u_a (
    .Clk         (clk),
    .Reset       (rst),
    .WriteEn     (we),
    .ReadEn      (re),
    .ClrReq      (clr),
    .DataAddress (addr),
    .DataIn      (din),
`ifdef DATA_MEM_PARITY_EN
    .ParInject   (inj),
    .ParErr      (a_pe),
`endif
    .DataOut     (a_do),
    .ReadValid   (a_rv),
    .Busy        (a_bz)
  );

  data_mem_param #(.DW(8), .AW(8), .DEPTH(DB), .INIT_VAL(8'h00)) u_b (
    .Clk         (clk),
    .Reset       (rst),
    .WriteEn     (we),
    .ReadEn      (re),
    .ClrReq      (clr),
    .DataAddress (addr),
    .DataIn      (din),
`ifdef DATA_MEM_PARITY_EN
    .ParInject   (inj),
    .ParErr      (b_pe),
`endif
    .DataOut     (b_do),
    .ReadValid   (b_rv),
    .Busy        (b_bz)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Word-level model: contents, clear cycles left, expected outputs.
  logic [7:0] mem  [2][256];
  bit         pbad [2][256];
  int         left [2];
  logic [7:0] e_do [2];
  bit         e_rv [2];
  bit         e_pe [2];
  int         depth [2] = '{DA, DB};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        left[k] = depth[k];
        e_do[k] = 8'h00;
        e_rv[k] = 0;
        e_pe[k] = 0;
      end else if (left[k] > 0) begin
        left[k] = left[k] - 1;
        e_rv[k] = 0;
        if (left[k] == 0) begin
          for (int i = 0; i < 256; i++) begin
            mem[k][i]  = 8'h00;
            pbad[k][i] = 0;
          end
        end
      end else if (clr) begin
        left[k] = depth[k];
        e_rv[k] = 0;
      end else begin
        e_rv[k] = re;
        if (re) begin
          if (int'(addr) < depth[k]) begin
            e_do[k] = mem[k][addr];
            e_pe[k] = pbad[k][addr];
          end else begin
            e_do[k] = 8'h00;
            e_pe[k] = 0;
          end
        end
        if (we && int'(addr) < depth[k]) begin
          mem[k][addr]  = din;
          pbad[k][addr] = inj;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy", 32'(a_bz), 32'(left[0] > 0));
      chk("a_rv",   32'(a_rv), 32'(e_rv[0]));
      chk("a_do",   32'(a_do), 32'(e_do[0]));
      chk("b_busy", 32'(b_bz), 32'(left[1] > 0));
      chk("b_rv",   32'(b_rv), 32'(e_rv[1]));
      chk("b_do",   32'(b_do), 32'(e_do[1]));
`ifdef DATA_MEM_PARITY_EN
      if (e_rv[0]) chk("a_pe", 32'(a_pe), 32'(e_pe[0]));
      if (e_rv[1]) chk("b_pe", 32'(b_pe), 32'(e_pe[1]));
`endif
    end
  end

  task automatic go(input bit w, input bit r, input bit c,
                    input logic [7:0] ad, input logic [7:0] d);
    we   = w;
    re   = r;
    clr  = c;
    addr = ad;
    din  = d;
    @(negedge clk);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    go(0, 0, 0, 8'h00, 8'h00);
    chk_en = 1;
    go(0, 0, 0, 8'h00, 8'h00);
    chk("rst_busy", 32'(a_bz), 32'd1);
    chk("rst_rv",   32'(a_rv), 32'd0);
    chk("rst_do",   32'(a_do), 32'h00);
    rst = 1'b0;

    n = 0;
    while (a_bz && n < 1000) begin
      go(0, 0, 0, 8'h00, 8'h00);
      n++;
    end
    chk("busy_len", n, 256);

    go(0, 1, 0, 8'h10, 8'h00);
    chk("rd10_rv", 32'(a_rv), 32'd1);
    chk("rd10_do", 32'(a_do), 32'h00);
    go(0, 0, 0, 8'h00, 8'h00);
    chk("idle_rv", 32'(a_rv), 32'd0);

    go(1, 0, 0, 8'h3C, 8'hA5);
    chk("wr_rv", 32'(a_rv), 32'd0);
    go(0, 1, 0, 8'h3C, 8'h00);
    chk("rd3c_do", 32'(a_do), 32'hA5);
    chk("rd3c_rv", 32'(a_rv), 32'd1);
    go(0, 0, 0, 8'h00, 8'h00);
    chk("idle2_rv", 32'(a_rv), 32'd0);
    chk("hold_do",  32'(a_do), 32'hA5);

    go(1, 1, 0, 8'h3C, 8'h77);
    chk("rbw_old", 32'(a_do), 32'hA5);
    go(0, 1, 0, 8'h3C, 8'h00);
    chk("rbw_new", 32'(a_do), 32'h77);

    go(1, 0, 1, 8'h05, 8'h11);
    chk("clr_busy", 32'(a_bz), 32'd1);
    n = 0;
    while (a_bz && n < 1000) begin
      go(1, 0, 0, 8'h05, 8'h22);
      n++;
    end
    chk("clr_len", n, 256);
    go(0, 1, 0, 8'h05, 8'h00);
    chk("clr_05", 32'(a_do), 32'h00);
    for (int i = 0; i < 256; i++) begin
      go(0, 1, 0, 8'(i), 8'h00);
      chk("clr_all", 32'(a_do), 32'h00);
    end

    go(1, 0, 0, 8'hC7, 8'h33);
    go(1, 0, 0, 8'hC8, 8'hFF);
    go(0, 1, 0, 8'hC8, 8'h00);
    chk("oor_do", 32'(b_do), 32'h00);
    chk("oor_rv", 32'(b_rv), 32'd1);
    go(0, 1, 0, 8'hC7, 8'h00);
    chk("c7_keep", 32'(b_do), 32'h33);

`ifdef DATA_MEM_PARITY_EN
    inj = 1'b1;
    go(1, 0, 0, 8'h40, 8'h5A);
    inj = 1'b0;
    go(0, 1, 0, 8'h40, 8'h00);
    chk("par_inj", 32'(a_pe), 32'd1);
    chk("par_do",  32'(a_do), 32'h5A);
    go(1, 0, 0, 8'h40, 8'h5A);
    go(0, 1, 0, 8'h40, 8'h00);
    chk("par_ok", 32'(a_pe), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
`ifdef DATA_MEM_PARITY_EN
      inj = ($urandom_range(0, 7) == 0);
`endif
      go($urandom_range(0, 1) == 1,
         $urandom_range(0, 1) == 1,
         $urandom_range(0, 299) == 0,
         8'($urandom_range(0, 255)),
         8'($urandom));
    end
    rst = 1'b0;
    inj = 1'b0;
    go(0, 0, 0, 8'h00, 8'h00);
    go(0, 0, 0, 8'h00, 8'h00);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
